// File: rtl/dsss_spreader.sv
// Spreads each accepted data bit into SF chips: chip = XNOR(PN, bit), PN from a Fibonacci LFSR.
// Latency: chip 0 appears one en-cycle after the accept; later chips follow one per en-cycle.
// Backpressure: data_ready is high only when idle or on the last chip of a bit; en=0 freezes all state.
module dsss_spreader #(
  parameter int unsigned       LFSR_W  = 7,
  parameter logic [LFSR_W-1:0] TAPS    = 7'h60,
  parameter logic [LFSR_W-1:0] SEED    = 7'h7F,
  parameter int unsigned       SF      = 8,
  parameter bit                SYNC_PN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic data_valid,
  input  logic data_in,
  output logic data_ready,
  output logic chip_out,
  output logic chip_valid,
  output logic bit_start,
  output logic pn_out
);

  localparam int unsigned       CNT_W    = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SF - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? {LFSR_W{1'b1}} : SEED;

  typedef enum logic {
    IDLE   = 1'b0,
    SPREAD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              bit_q, bit_d;
  logic              chip_out_q, chip_out_d;
  logic              chip_valid_q, chip_valid_d;
  logic              bit_start_q, bit_start_d;
  logic              pn_out_q, pn_out_d;

  logic              accept;
  logic [LFSR_W-1:0] pn_src;
  logic              pn_cur;

  // One LFSR step; a zero register reloads the seed instead of staying stuck.
  function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] cur);
    if (cur == '0) begin
      return SEED_EFF;
    end
    return {cur[LFSR_W-2:0], ^(cur & TAPS)};
  endfunction

  assign data_ready = en & ~rst & ((state_q == IDLE) | (cnt_q == CNT_LAST));
  assign accept     = data_valid & data_ready;

  assign chip_out   = chip_out_q;
  assign chip_valid = chip_valid_q;
  assign bit_start  = bit_start_q;
  assign pn_out     = pn_out_q;

  // Next-state logic: load chip 0 on accept, step through the bit, drop to idle after the last chip.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    bit_d        = bit_q;
    chip_out_d   = chip_out_q;
    chip_valid_d = chip_valid_q;
    bit_start_d  = bit_start_q;
    pn_out_d     = pn_out_q;

    // In synchronous mode every bit starts its PN from the seed.
    pn_src = (SYNC_PN && accept) ? SEED_EFF : lfsr_q;
    pn_cur = pn_src[LFSR_W-1];

    if (en) begin
      if (accept) begin
        state_d      = SPREAD;
        cnt_d        = '0;
        bit_d        = data_in;
        lfsr_d       = lfsr_adv(pn_src);
        pn_out_d     = pn_cur;
        chip_out_d   = ~(pn_cur ^ data_in);
        chip_valid_d = 1'b1;
        bit_start_d  = 1'b1;
      end else if (state_q == SPREAD) begin
        if (cnt_q != CNT_LAST) begin
          cnt_d        = cnt_q + 1'b1;
          lfsr_d       = lfsr_adv(lfsr_q);
          pn_out_d     = pn_cur;
          chip_out_d   = ~(pn_cur ^ bit_q);
          chip_valid_d = 1'b1;
          bit_start_d  = 1'b0;
        end else begin
          state_d      = IDLE;
          chip_valid_d = 1'b0;
          bit_start_d  = 1'b0;
        end
      end
    end
  end

  // State and output registers; reset restores the seed so the next bit restarts the PN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lfsr_q       <= SEED_EFF;
      bit_q        <= 1'b0;
      chip_out_q   <= 1'b0;
      chip_valid_q <= 1'b0;
      bit_start_q  <= 1'b0;
      pn_out_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      bit_q        <= bit_d;
      chip_out_q   <= chip_out_d;
      chip_valid_q <= chip_valid_d;
      bit_start_q  <= bit_start_d;
      pn_out_q     <= pn_out_d;
    end
  end

endmodule
